// File: rtl/dispense_sequencer.sv
// Candy dispense sequencer: one request runs flap open, auger stepping,
// agitator run and flap close, then waits for the Pi to drop its request.
module dispense_sequencer #(
  parameter int   STEP_HALF  = 3000,
  parameter int   SETTLE_CYC = 6000000,
  parameter int   DC_CYC     = 12000000,
  parameter int   STEPS_S    = 200,
  parameter int   STEPS_M    = 400,
  parameter int   STEPS_L    = 800,
  parameter logic STEP_DIR   = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       candy_flag,
  input  logic [1:0] amount,
  output logic       ack,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       servo_open,
  output logic       step_out,
  output logic       step_dir,
  output logic       dc_en
);

  localparam int MAX_A     = (SETTLE_CYC > DC_CYC) ? SETTLE_CYC : DC_CYC;
  localparam int MAX_CNT   = (MAX_A > 2 * STEP_HALF) ? MAX_A : 2 * STEP_HALF;
  localparam int CNT_W     = $clog2(MAX_CNT + 1);
  localparam int MAX_SM    = (STEPS_S > STEPS_M) ? STEPS_S : STEPS_M;
  localparam int MAX_STEPS = (MAX_SM > STEPS_L) ? MAX_SM : STEPS_L;
  localparam int STP_W     = $clog2(MAX_STEPS + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DC_LAST     = CNT_W'(DC_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_CNT    = CNT_W'(STEP_HALF);
  localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(STEP_HALF - 1);
  localparam logic [CNT_W-1:0] PER_LAST    = CNT_W'(2 * STEP_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_OPEN, S_STEP, S_DC, S_CLOSE, S_WAIT_REL
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [STP_W-1:0]   r_steps;
  logic [STP_W-1:0]   r_target;
  logic               r_ack;
  logic               r_flag_s1;
  logic               r_flag_s2;
  logic               r_flag_d;
  logic [1:0]         r_amt_s1;
  logic [1:0]         r_amt_s2;
  logic [1:0]         r_warm;
  logic               r_armed;
  logic               w_req;

  // Synchronize Pi inputs; arm edge detection only once the synced flag is
  // seen low after reset, so a flag held through reset cannot start a cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_flag_s1 <= 1'b0;
      r_flag_s2 <= 1'b0;
      r_flag_d  <= 1'b0;
      r_amt_s1  <= 2'b00;
      r_amt_s2  <= 2'b00;
      r_warm    <= 2'd0;
      r_armed   <= 1'b0;
    end else begin
      r_flag_s1 <= candy_flag;
      r_flag_s2 <= r_flag_s1;
      r_flag_d  <= r_flag_s2;
      r_amt_s1  <= amount;
      r_amt_s2  <= r_amt_s1;
      if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
      if (r_warm == 2'd2 && !r_flag_s2) r_armed <= 1'b1;
    end
  end

  assign w_req = r_armed & r_flag_s2 & ~r_flag_d;

  // State register, phase counter, step counter, target and ack latch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_steps  <= '0;
      r_target <= '0;
      r_ack    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == S_STEP && r_cnt == PER_LAST)
        r_cnt <= '0;
      else if (r_state == S_OPEN || r_state == S_STEP ||
               r_state == S_DC || r_state == S_CLOSE)
        r_cnt <= r_cnt + 1'b1;

      if (r_state != S_STEP)
        r_steps <= '0;
      else if (r_cnt == HALF_LAST)
        r_steps <= r_steps + 1'b1;

      if (r_state == S_LATCH) begin
        case (r_amt_s2)
          2'b00:   r_target <= STP_W'(STEPS_S);
          2'b01:   r_target <= STP_W'(STEPS_M);
          default: r_target <= STP_W'(STEPS_L);
        endcase
        r_ack <= (r_amt_s2 != 2'b11);
      end else if (w_next == S_IDLE) begin
        r_ack <= 1'b0;
      end
    end
  end

  // Next-state decode; every terminal compare is exact, counters never wrap.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (w_req) w_next = S_LATCH;
      S_LATCH:    w_next = (r_amt_s2 == 2'b11) ? S_WAIT_REL : S_OPEN;
      S_OPEN:     if (r_cnt == SETTLE_LAST) w_next = S_STEP;
      S_STEP:     if (r_cnt == PER_LAST && r_steps == r_target) w_next = S_DC;
      S_DC:       if (r_cnt == DC_LAST) w_next = S_CLOSE;
      S_CLOSE:    if (r_cnt == SETTLE_LAST) w_next = S_WAIT_REL;
      S_WAIT_REL: if (!r_flag_s2) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Actuator and status outputs decoded from state so reset drops them at once.
  always_comb begin
    ack        = r_ack;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    servo_open = 1'b0;
    step_out   = 1'b0;
    step_dir   = 1'b0;
    dc_en      = 1'b0;
    unique case (r_state)
      S_LATCH: begin
        busy = 1'b1;
        err  = (r_amt_s2 == 2'b11);
      end
      S_OPEN: begin
        busy       = 1'b1;
        servo_open = 1'b1;
      end
      S_STEP: begin
        busy       = 1'b1;
        servo_open = 1'b1;
        step_dir   = STEP_DIR;
        step_out   = (r_cnt < HALF_CNT);
      end
      S_DC: begin
        busy       = 1'b1;
        servo_open = 1'b1;
        dc_en      = 1'b1;
      end
      S_CLOSE: begin
        busy = 1'b1;
        done = (r_cnt == SETTLE_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer with shortened timing parameters.
module tb_dispense_sequencer;

  logic       clk;
  logic       rstn;
  logic       candy_flag;
  logic [1:0] amount;
  logic       ack, busy, done, err, servo_open, step_out, step_dir, dc_en;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int steps;
    bit is_err;
  } exp_t;
  exp_t sb[$];

  int  mon_edges = 0;
  bit  mon_prev  = 1'b0;

  dispense_sequencer #(
    .STEP_HALF (2),
    .SETTLE_CYC(10),
    .DC_CYC    (20),
    .STEPS_S   (3),
    .STEPS_M   (5),
    .STEPS_L   (8),
    .STEP_DIR  (1'b1)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .candy_flag(candy_flag),
    .amount    (amount),
    .ack       (ack),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .servo_open(servo_open),
    .step_out  (step_out),
    .step_dir  (step_dir),
    .dc_en     (dc_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: counts step rising edges per cycle, pops on done/err.
  always @(negedge clk) begin
    if (!rstn) begin
      mon_edges = 0;
      mon_prev  = 1'b0;
    end else begin
      if (step_out && !mon_prev) mon_edges++;
      mon_prev = step_out;
      if (done || err) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: done=%0b err=%0b edges=%0d with no pending request", done, err, mon_edges);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (err !== e.is_err || done !== !e.is_err || mon_edges != e.steps) begin
            bad++;
            $display("FAIL sb_result: got err=%0b done=%0b edges=%0d, expected err=%0b edges=%0d",
                     err, done, mon_edges, e.is_err, e.steps);
          end
        end
        mon_edges = 0;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Full valid dispense with phase timing checks; leaves the flag high.
  task automatic do_cycle(input logic [1:0] amt, input int steps);
    int n;
    int errs;
    int dpos;
    exp_t e;
    e.steps = steps;
    e.is_err = 1'b0;
    amount = amt;
    sb.push_back(e);
    candy_flag = 1'b1;
    n = 0;
    while (!ack && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n != 4 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ack_latency: got %0d clk busy=%0b, expected 4 clk busy=1", n, busy);
    end
    n = 0;
    while (servo_open && !step_out && !dc_en && n < 100) begin n++; @(negedge clk); end
    total++;
    if (n != 10) begin
      bad++;
      $display("FAIL open_len: got %0d, expected 10", n);
    end
    n = 0;
    errs = 0;
    while (!dc_en && n < 400) begin
      if (step_out !== ((n % 4) < 2) || step_dir !== 1'b1 || servo_open !== 1'b1) errs++;
      n++;
      @(negedge clk);
    end
    total++;
    if (n != steps * 4 || errs != 0) begin
      bad++;
      $display("FAIL step_phase: got len=%0d pattern_errs=%0d, expected len=%0d errs=0", n, errs, steps * 4);
    end
    n = 0;
    errs = 0;
    while (dc_en && n < 200) begin
      if (servo_open !== 1'b1 || step_out !== 1'b0 || step_dir !== 1'b0) errs++;
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 20 || errs != 0) begin
      bad++;
      $display("FAIL dc_phase: got len=%0d errs=%0d, expected len=20 errs=0", n, errs);
    end
    n = 0;
    errs = 0;
    dpos = -1;
    while (busy && n < 100) begin
      if (done) dpos = n;
      if (servo_open || dc_en || step_out) errs++;
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 10 || dpos != 9 || errs != 0) begin
      bad++;
      $display("FAIL close_phase: got len=%0d done_at=%0d errs=%0d, expected len=10 done_at=9 errs=0",
               n, dpos, errs);
    end
    total++;
    if (ack !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL wait_rel_state: got ack=%0b done=%0b, expected ack=1 done=0", ack, done);
    end
  endtask

  task automatic release_flag();
    int n;
    candy_flag = 1'b0;
    n = 0;
    while (ack && n < 20) begin @(negedge clk); n++; end
    tick(2);
    total++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL release: got ack=%0b busy=%0b, expected 0 0", ack, busy);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    candy_flag = 1'b0;
    amount = 2'b00;
    #1;
    total++;
    if ({ack, busy, done, err, servo_open, step_out, step_dir, dc_en} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: got %b, expected 00000000",
               {ack, busy, done, err, servo_open, step_out, step_dir, dc_en});
    end
    tick(3);
    rstn = 1'b1;
    tick(6);
    total++;
    if ({ack, busy, servo_open, dc_en} !== 4'h0) begin
      bad++;
      $display("FAIL post_reset_idle: got %b, expected 0000", {ack, busy, servo_open, dc_en});
    end
  endtask

  task automatic test_small();
    do_cycle(2'b00, 3);
    tick(5);
    total++;
    if (ack !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_wait_rel: got ack=%0b busy=%0b, expected 1 0", ack, busy);
    end
    release_flag();
  endtask

  task automatic test_amounts();
    do_cycle(2'b10, 8);
    release_flag();
    do_cycle(2'b01, 5);
    release_flag();
  endtask

  task automatic test_invalid();
    int n;
    int errs;
    exp_t e;
    e.steps = 0;
    e.is_err = 1'b1;
    sb.push_back(e);
    amount = 2'b11;
    candy_flag = 1'b1;
    n = 0;
    errs = 0;
    while (!err && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL err_latency: got %0d, expected 3", n);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ack || servo_open || step_out || dc_en || busy || err) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL err_quiet: got %0d active cycles, expected 0", errs);
    end
    candy_flag = 1'b0;
    tick(6);
    total++;
    if ({ack, busy, err} !== 3'b000) begin
      bad++;
      $display("FAIL err_release: got %b, expected 000", {ack, busy, err});
    end
  endtask

  task automatic test_ignore_during_step();
    int n;
    int busy_cnt;
    exp_t e;
    e.steps = 3;
    e.is_err = 1'b0;
    sb.push_back(e);
    amount = 2'b00;
    candy_flag = 1'b1;
    n = 0;
    while (!step_out && n < 100) begin @(negedge clk); n++; end
    amount = 2'b10;
    candy_flag = 1'b0;
    tick(3);
    candy_flag = 1'b1;
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL ignore_done_timeout: got done=%0b after %0d clk, expected 1", done, n);
    end
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    total++;
    if (busy_cnt != 0 || ack !== 1'b1) begin
      bad++;
      $display("FAIL ignore_no_restart: got busy_cycles=%0d ack=%0b, expected 0 1", busy_cnt, ack);
    end
    release_flag();
  endtask

  task automatic test_reset_mid();
    int n;
    int busy_cnt;
    exp_t e;
    e.steps = 3;
    e.is_err = 1'b0;
    sb.push_back(e);
    amount = 2'b00;
    candy_flag = 1'b1;
    n = 0;
    while (!dc_en && n < 200) begin @(negedge clk); n++; end
    tick(3);
    rstn = 1'b0;
    #1;
    total++;
    if ({dc_en, servo_open, busy, ack, step_out} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_mid_outputs: got %b, expected 00000", {dc_en, servo_open, busy, ack, step_out});
    end
    void'(sb.pop_front());
    tick(2);
    rstn = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy || ack) busy_cnt++;
    end
    total++;
    if (busy_cnt != 0) begin
      bad++;
      $display("FAIL reset_held_flag: got %0d busy cycles, expected 0", busy_cnt);
    end
    candy_flag = 1'b0;
    tick(6);
    do_cycle(2'b00, 3);
    release_flag();
  endtask

  task automatic test_back_to_back();
    int busy_cnt;
    int ack_lo;
    do_cycle(2'b01, 5);
    busy_cnt = 0;
    ack_lo = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (!ack) ack_lo++;
    end
    total++;
    if (busy_cnt != 0 || ack_lo != 0) begin
      bad++;
      $display("FAIL held_after_done: got busy_cycles=%0d ack_low=%0d, expected 0 0", busy_cnt, ack_lo);
    end
    release_flag();
    do_cycle(2'b10, 8);
    release_flag();
  endtask

  initial begin
    test_reset();
    test_small();
    test_amounts();
    test_invalid();
    test_ignore_during_step();
    test_reset_mid();
    test_back_to_back();
    tick(3);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
